cordic_trig_mc: RTL and testbench
=================================

Name: cordic_trig_mc

Overview:
- Multi-cycle iterative CORDIC unit computing cos or sin of an IEEE-754 single-precision angle in radians, |angle| <= 1.0.
- Successor to the combinational cosine block:
  - parametrised fixed-point width and iteration count;
  - cos/sin mode select;
  - clk_en/start/done multi-cycle handshake, suitable for a Nios II multi-cycle custom instruction slot;
  - out-of-range detection.
- Area-oriented: one shared shift/add datapath reused for ITER cycles.

Parameters:
- W, 32: internal fixed-point width, signed Q2.(W-2); legal 18..34.
- ITER, 24: CORDIC iterations; legal 8..W-2.
- ATAN table: derived internally, ITER entries of atan(2^-i) in Q2.(W-2), truncated.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- clk_en, input, 1: when low, all state and outputs hold.
- start, input, 1: begin operation; sampled only in IDLE with clk_en=1.
- n, input, 1: mode, sampled with start; 0 = cos, 1 = sin.
- dataa, input, 32: float32 angle, sampled with start.
- result, output, 32: float32 result, held until the next done.
- done, output, 1: single-cycle completion pulse.
- busy, output, 1: high in every state except IDLE.
- range_err, output, 1: valid with done; 1 when |angle| > 1.0, or the input is Inf or NaN.

Behaviour:
- Reset: state=IDLE; result=0x00000000; done=0; busy=0; range_err=0. Asserting reset mid-operation aborts the operation immediately, with no done.
- All transitions below require clk_en=1. With clk_en=0, state, counters and outputs freeze, including a pending done.
- IDLE -> CONV:
  - on start; latch n, sign of dataa, exponent e, mantissa.
  - start while busy is ignored; there is no queueing.
- CONV, one cycle:
  - e==0 (zero or denormal): z=0.
  - e>127 (includes Inf/NaN): set err flag; skip to NORM with result forced to 0x7FC00000.
  - otherwise z = {1,mant} aligned so that 1.0 = 1<<(W-2), shifted right by (127-e), truncated. Shifts >= W give z=0.
  - Always compute on |angle|.
  - x = K = round(0.6072529350 * 2^(W-2)); y = 0; i = 0.
- ITER, ITER cycles:
  - d = (z>=0) ? +1 : -1.
  - x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*ATAN[i].
  - Shifts are arithmetic; sums wrap at W bits (no overflow is reachable in range).
  - i increments each cycle; leave after i==ITER-1.
- NORM, one cycle:
  - v = x (cos) or y (sin).
  - Clamp negative v to 0; this covers tiny-angle sin residue.
  - Leading-one detect gives position p. Exponent = 127 + p - (W-2). Mantissa = the 23 bits below the leading one, truncated; zero-pad if fewer are available.
  - v==0 -> +0.0.
  - sin with negative input sets the sign bit; cos never sets it.
  - err path -> 0x7FC00000.
- DONE, one cycle:
  - result updated, done=1, range_err valid, busy=1.
  - Next state IDLE. done returns to 0 on the next enabled cycle.
- Latency: start edge to done-high edge = ITER+3 enabled clocks (24-iteration default: 27). With a start held continuously, the next operation begins at IDLE, one cycle after done.
- Accuracy, in range: |result - true| <= 2^-(ITER-3) absolute.

Test Plan:
- Reset: hold reset_n=0 with random dataa/start -> result=0, done=0, busy=0. Then release, start with dataa=0x3F800000, n=0, and assert reset_n=0 at cycle 10 -> no done; busy=0 immediately.
- Known values, ITER=24, each checked within 2^-21 absolute; range_err=0 and latency exactly 27 for all:
  - 0x3F800000 (1.0), cos -> ~0x3F0A5140.
  - 0xBF800000 (-1.0), cos -> ~0x3F0A5140.
  - 0x3F800000 (1.0), sin -> ~0x3F576AA4.
  - 0xBF800000 (-1.0), sin -> ~0xBF576AA4 (sign set).
  - 0x3F000000 (0.5), cos -> ~0x3F60A940.
  - 0x3F000000 (0.5), sin -> ~0x3EF57744.
- Edge inputs:
  - 0x00000000, cos -> ~1.0 (0x3F7FFFxx..0x3F800000).
  - 0x00000000, sin -> 0x00000000.
  - 0x33800000 (2^-30), sin -> magnitude <= 2^-21, sign bit 0.
- Range errors: 0x3F800001, 0x40000000, 0x7F800000, 0x7FC00000 -> result 0x7FC00000 with range_err=1 on done.
- Handshake: pulse start again during ITER with a different dataa -> ignored; result matches the first operation. Drop clk_en for 5 cycles mid-ITER -> done is delayed by exactly 5 cycles, with the same result.
- Back-to-back: start held high for 3 operations -> done pulses every 28 cycles, each exactly 1 cycle wide. Sweep 256 random in-range angles in both modes against a real-valued model within tolerance.

Source files
------------

// File: rtl/cordic_trig_mc.sv
// cordic_trig_mc: multi-cycle iterative CORDIC cos/sin of a float32 angle.
// One shift/add datapath is reused for ITER rotation steps.
module cordic_trig_mc #(
    parameter int W    = 32,
    parameter int ITER = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic        n,
    input  logic [31:0] dataa,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        range_err
);

    localparam int IW = $clog2(ITER);
    localparam int PW = $clog2(W);
    localparam logic [127:0] K_WIDE =
        ((128'd6072529350 << (W - 2)) + 128'd5000000000) / 128'd10000000000;
    localparam logic signed [W-1:0] K = K_WIDE[W-1:0];
    localparam logic [63:0] ONE = 64'h1000_0000_0000_0000;

    // atan(1/q) as an alternating series in Q.60; sh>0 means q = 2^(sh/2)
    function automatic logic [63:0] series(
        input logic [63:0] t0, input logic [63:0] q2, input int sh);
        logic [63:0] t;
        logic [63:0] s;
        t = t0;
        s = '0;
        for (int k = 0; k < 64; k++) begin
            if (k[0]) s = s - t / 64'(2 * k + 1);
            else      s = s + t / 64'(2 * k + 1);
            if (sh > 0) t = t >> sh;
            else        t = t / q2;
        end
        return s;
    endfunction

    function automatic logic [W-1:0] atan_q(input int i);
        logic [63:0] f;
        if (i == 0)
            f = 4 * series(ONE / 5, 64'd25, 0) - series(ONE / 239, 64'd57121, 0);
        else
            f = series(ONE >> i, 64'd0, 2 * i);
        return W'(f >> (60 - (W - 2)));
    endfunction

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_ITER, S_NORM, S_DONE
    } state_t;

    state_t state;

    logic [W-1:0] atan_tab [2**IW];
    for (genvar g = 0; g < 2**IW; g++) begin : g_atan
        localparam logic [W-1:0] A = (g < ITER) ? atan_q(g) : '0;
        assign atan_tab[g] = A;
    end

    logic                n_q, sgn_q, err_q;
    logic [7:0]          e_q;
    logic [22:0]         m_q;
    logic signed [W-1:0] x, y, z;
    logic [IW-1:0]       i;
    logic [31:0]         fp_q;

    logic                err_c;
    logic [7:0]          sh;
    logic [8:0]          amt;
    logic [W+23:0]       al;
    logic signed [W-1:0] z0;

    always_comb begin
        err_c = (e_q > 8'd127) || (e_q == 8'd127 && m_q != '0);
        sh    = 8'd127 - e_q;
        amt   = 9'd23 + {1'b0, sh};
        al    = (W + 24)'({1'b1, m_q}) << (W - 2);
        z0    = W'(al >> amt);
        if (e_q == 8'd0 || {1'b0, sh} >= 9'(W))
            z0 = '0;
    end

    logic signed [W-1:0] xs, ys;
    logic                d;

    always_comb begin
        xs = x >>> i;
        ys = y >>> i;
        d  = ~z[W-1];
    end

    logic signed [W-1:0] v;
    logic [PW-1:0]       p;
    logic [PW-1:0]       lsh;
    logic [W-1:0]        nrm;
    logic [W+22:0]       wide;
    logic [7:0]          expo;
    logic [31:0]         fp_c;

    // Leading-one normalise of the clamped CORDIC output into float32
    always_comb begin
        v = n_q ? y : x;
        if (v[W-1])
            v = '0;
        p = '0;
        for (int k = 0; k < W; k++)
            if (v[k]) p = PW'(k);
        lsh  = PW'(W - 1) - p;
        nrm  = v << lsh;
        wide = {nrm, 23'b0};
        expo = 8'(127 - (W - 2)) + 8'(p);
        if (err_q)
            fp_c = 32'h7FC0_0000;
        else if (v == '0)
            fp_c = '0;
        else
            fp_c = {n_q & sgn_q, expo, wide[W+21 -: 23]};
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            result    <= '0;
            done      <= 1'b0;
            range_err <= 1'b0;
            n_q       <= 1'b0;
            sgn_q     <= 1'b0;
            err_q     <= 1'b0;
            e_q       <= '0;
            m_q       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            fp_q      <= '0;
        end else if (clk_en) begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q   <= n;
                        sgn_q <= dataa[31];
                        e_q   <= dataa[30:23];
                        m_q   <= dataa[22:0];
                        state <= S_CONV;
                    end
                end
                S_CONV: begin
                    err_q <= err_c;
                    x     <= K;
                    y     <= '0;
                    z     <= z0;
                    i     <= '0;
                    state <= err_c ? S_NORM : S_ITER;
                end
                S_ITER: begin
                    if (d) begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - $signed(atan_tab[i]);
                    end else begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + $signed(atan_tab[i]);
                    end
                    i <= i + 1'b1;
                    if (i == IW'(ITER - 1))
                        state <= S_NORM;
                end
                S_NORM: begin
                    fp_q  <= fp_c;
                    state <= S_DONE;
                end
                S_DONE: begin
                    result    <= fp_q;
                    done      <= 1'b1;
                    range_err <= err_q;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_trig_mc.sv
// tb_cordic_trig_mc: directed table, handshake sequences and a random
// sweep for the multi-cycle CORDIC cos/sin unit.
module tb_cordic_trig_mc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk_en;
    logic        start;
    logic        n;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        range_err;

    cordic_trig_mc #(.W(32), .ITER(24)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .start     (start),
        .n         (n),
        .dataa     (dataa),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    localparam real TOL = 1.0 / 2097152.0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] a;
        logic        md;
        logic        err;
        real         want;
        string       name;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] res_tab[$];

    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        r = 1.0 + real'(int'(b[22:0])) / 8388608.0;
        for (int k = e; k < 127; k++) r = r / 2.0;
        for (int k = 127; k < e; k++) r = r * 2.0;
        return b[31] ? -r : r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic chk_real(input string nm, input logic [31:0] got,
                            input real want);
        real diff;
        tests++;
        diff = f2r(got) - want;
        if (diff < 0.0) diff = -diff;
        if (!(diff <= TOL)) begin
            fails++;
            $display("FAIL %s: got %h (%g), want %g within %g",
                     nm, got, f2r(got), want, TOL);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic md, input logic err,
                       input real want, input string name);
        vec_t t;
        t.a = a; t.md = md; t.err = err; t.want = want; t.name = name;
        vq.push_back(t);
    endtask

    // Called at a negedge with the unit idle; returns at the negedge after
    // the sampling edge.
    task automatic start_op(input logic [31:0] a, input logic md);
        dataa = a;
        n     = md;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int l0, output int lat);
        lat = l0;
        while (!done && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout: no done after %0d cycles", lat);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          cnt;
        int          pulses[$];
        logic [31:0] a;
        logic        md;
        real         ang;

        add(32'h3F80_0000, 1'b0, 1'b0,  0.5403023058681398, "cos(+1)");
        add(32'hBF80_0000, 1'b0, 1'b0,  0.5403023058681398, "cos(-1)");
        add(32'h3F80_0000, 1'b1, 1'b0,  0.8414709848078965, "sin(+1)");
        add(32'hBF80_0000, 1'b1, 1'b0, -0.8414709848078965, "sin(-1)");
        add(32'h3F00_0000, 1'b0, 1'b0,  0.8775825618903728, "cos(0.5)");
        add(32'h3F00_0000, 1'b1, 1'b0,  0.4794255386042030, "sin(0.5)");
        add(32'h0000_0000, 1'b0, 1'b0,  1.0,                "cos(0)");
        add(32'h0000_0000, 1'b1, 1'b0,  0.0,                "sin(0)");
        add(32'h3380_0000, 1'b1, 1'b0,  0.0,                "sin(2^-30)");
        add(32'h3F80_0001, 1'b0, 1'b1,  0.0,                "err 1+ulp");
        add(32'h4000_0000, 1'b1, 1'b1,  0.0,                "err 2.0");
        add(32'h7F80_0000, 1'b0, 1'b1,  0.0,                "err inf");
        add(32'h7FC0_0000, 1'b1, 1'b1,  0.0,                "err nan");

        reset_n = 1'b0;
        clk_en  = 1'b1;
        start   = 1'b0;
        n       = 1'b0;
        dataa   = '0;

        repeat (5) begin
            @(negedge clk);
            dataa = $urandom;
            start = 1'($urandom_range(0, 1));
            n     = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("reset result", result, 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset range_err", 32'(range_err), 32'h0);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);

        start_op(32'h3F80_0000, 1'b0);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("busy mid-op", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort done", 32'(done), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort no done", 32'(cnt), 32'h0);

        for (int k = 0; k < vq.size(); k++) begin
            start_op(vq[k].a, vq[k].md);
            wait_done(0, lat);
            res_tab.push_back(result);
            chk({vq[k].name, " range_err"}, 32'(range_err), 32'(vq[k].err));
            if (!vq[k].err) begin
                chk_real({vq[k].name, " value"}, result, vq[k].want);
                chk({vq[k].name, " sign"}, 32'(result[31]),
                    32'(vq[k].want < 0.0));
                chk({vq[k].name, " latency"}, 32'(lat), 32'd27);
            end else begin
                chk({vq[k].name, " result"}, result, 32'h7FC0_0000);
            end
        end

        // A second start during rotation must be dropped
        start_op(32'h3F00_0000, 1'b1);
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        dataa = 32'h3F80_0000;
        n     = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(9, lat);
        chk("ignored start latency", 32'(lat), 32'd27);
        chk("ignored start result", result, res_tab[5]);
        chk("ignored start err", 32'(range_err), 32'h0);

        // Five disabled cycles mid-rotation stretch latency by five
        start_op(32'h3F80_0000, 1'b0);
        lat = 0;
        repeat (10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        clk_en = 1'b0;
        repeat (5) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("freeze busy", 32'(busy), 32'h1);
        clk_en = 1'b1;
        wait_done(lat, lat);
        chk("clk_en latency", 32'(lat), 32'd32);
        chk("clk_en result", result, res_tab[0]);

        // A pending done holds while disabled
        clk_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("done held", 32'(done), 32'h1);
        clk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("done cleared", 32'(done), 32'h0);

        // Start held high: done every 28 cycles, one cycle wide
        dataa = 32'h3F00_0000;
        n     = 1'b0;
        start = 1'b1;
        for (int c = 0; c < 86; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) pulses.push_back(c);
        end
        start = 1'b0;
        chk("b2b pulse count", 32'(pulses.size()), 32'd3);
        for (int k = 0; k < pulses.size() && k < 3; k++)
            chk($sformatf("b2b pulse %0d cycle", k),
                32'(pulses[k]), 32'(27 + 28 * k));
        chk("b2b result", result, res_tab[4]);
        wait_done(0, lat);
        @(posedge clk);
        @(negedge clk);

        for (int k = 0; k < 512; k++) begin
            a   = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 126)),
                   23'($urandom)};
            md  = 1'(k & 1);
            ang = f2r(a);
            start_op(a, md);
            wait_done(0, lat);
            chk_real($sformatf("sweep %h n=%0d", a, md), result,
                     md ? $sin(ang) : $cos(ang));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
